// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor: one full-subtractor slice walks a WIDTH-bit operand
// pair LSB first, one bit per clock, and reports difference and final borrow.
module serial_sub_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] sd_q, sd_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             br_q, br_d;
  logic             borrow_q, borrow_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             slice_d, slice_b;

  always_comb begin
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    sd_d     = sd_q;
    br_d     = br_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;

    slice_d = sa_q[0] ^ sb_q[0] ^ br_q;
    slice_b = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & br_q);

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          sa_d    = a;
          sb_d    = b;
          br_d    = 1'b0;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        // Difference bits enter at the MSB so bit 0 lands at the LSB after WIDTH shifts.
        sd_d  = {slice_d, sd_q[WIDTH-1:1]};
        sa_d  = {1'b0, sa_q[WIDTH-1:1]};
        sb_d  = {1'b0, sb_q[WIDTH-1:1]};
        br_d  = slice_b;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d  = DONE;
          diff_d   = sd_d;
          borrow_d = slice_b;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      sa_q     <= '0;
      sb_q     <= '0;
      sd_q     <= '0;
      br_q     <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      sd_q     <= sd_d;
      br_q     <= br_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
    end
  end

  assign busy       = (state_q == RUN);
  assign done       = (state_q == DONE);
  assign diff       = diff_q;
  assign borrow_out = borrow_q;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Directed bench for serial_sub_ctrl at WIDTH=8 and WIDTH=4 (exhaustive).
module tb_serial_sub_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start8 = 1'b0, start4 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       busy8, done8, bo8, busy4, done4, bo4;
  logic [7:0] diff8;
  logic [3:0] diff4;

  int vectors = 0;
  int fails   = 0;
  logic [7:0] prev_d8 = '0;
  logic       prev_b8 = 1'b0;
  logic [3:0] prev_d4 = '0;
  logic       prev_b4 = 1'b0;

  serial_sub_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow_out(bo8)
  );

  serial_sub_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .diff(diff4), .borrow_out(bo4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single WIDTH=8 operation from IDLE; checks latency, busy span, result and hold.
  task automatic op8(input logic [7:0] ta, input logic [7:0] tb_, input logic [7:0] ed,
                     input logic eb, input string tag);
    int n;
    start8 = 1'b1; a8 = ta; b8 = tb_;
    tick();
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
    n = 0;
    while (busy8 === 1'b1 && n < 20) begin
      if (n == 4) begin
        chk({tag, "_hold_diff"}, 32'(diff8), 32'(prev_d8));
        chk({tag, "_hold_bo"}, 32'(bo8), 32'(prev_b8));
      end
      n++;
      tick();
    end
    chk({tag, "_busy_cycles"}, 32'(n), 32'd8);
    chk({tag, "_done"}, 32'(done8), 32'd1);
    chk({tag, "_diff"}, 32'(diff8), 32'(ed));
    chk({tag, "_borrow"}, 32'(bo8), 32'(eb));
    tick();
    chk({tag, "_done_fall"}, 32'(done8), 32'd0);
    prev_d8 = ed; prev_b8 = eb;
  endtask

  initial begin
    int n;
    int done_cnt;
    logic [3:0] ta, tb_;
    logic [3:0] ed4;
    logic       eb4;

    #2;
    chk("rst_busy", 32'(busy8), 32'd0);
    chk("rst_done", 32'(done8), 32'd0);
    chk("rst_diff", 32'(diff8), 32'd0);
    chk("rst_borrow", 32'(bo8), 32'd0);
    #20 rst = 1'b0;
    tick();

    op8(8'h5A, 8'h3C, 8'h1E, 1'b0, "basic");
    op8(8'h00, 8'h01, 8'hFF, 1'b1, "underflow");
    op8(8'h80, 8'h80, 8'h00, 1'b0, "equal");

    // start pulsed every RUN cycle with changing operands
    start8 = 1'b1; a8 = 8'hC3; b8 = 8'h5A;
    tick();
    n = 0;
    while (busy8 === 1'b1 && n < 20) begin
      start8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom);
      n++;
      tick();
    end
    start8 = 1'b0;
    chk("ignore_busy_cycles", 32'(n), 32'd8);
    chk("ignore_done", 32'(done8), 32'd1);
    chk("ignore_diff", 32'(diff8), 32'h69);
    chk("ignore_borrow", 32'(bo8), 32'd0);
    done_cnt = 0;
    repeat (12) begin
      tick();
      if (done8 === 1'b1) done_cnt++;
    end
    chk("ignore_extra_done", 32'(done_cnt), 32'd0);
    chk("ignore_idle", 32'(busy8), 32'd0);

    // start held high: back-to-back issue every 9 cycles
    start8 = 1'b1; a8 = 8'h10; b8 = 8'h01;
    tick();
    a8 = 8'h03; b8 = 8'h05;
    repeat (7) tick();
    chk("b2b_done_early", 32'(done8), 32'd0);
    tick();
    chk("b2b_done1", 32'(done8), 32'd1);
    chk("b2b_busy1", 32'(busy8), 32'd0);
    chk("b2b_diff1", 32'(diff8), 32'h0F);
    chk("b2b_borrow1", 32'(bo8), 32'd0);
    tick();
    chk("b2b_reaccept", 32'(busy8), 32'd1);
    chk("b2b_hold", 32'(diff8), 32'h0F);
    start8 = 1'b0;
    repeat (7) tick();
    chk("b2b_done2_early", 32'(done8), 32'd0);
    tick();
    chk("b2b_done2", 32'(done8), 32'd1);
    chk("b2b_diff2", 32'(diff8), 32'hFE);
    chk("b2b_borrow2", 32'(bo8), 32'd1);
    tick();
    prev_d8 = 8'hFE; prev_b8 = 1'b1;

    // asynchronous reset mid-RUN
    start8 = 1'b1; a8 = 8'h01; b8 = 8'h02;
    tick();
    start8 = 1'b0;
    repeat (3) tick();
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy8), 32'd0);
    chk("arst_done", 32'(done8), 32'd0);
    chk("arst_diff", 32'(diff8), 32'd0);
    chk("arst_borrow", 32'(bo8), 32'd0);
    #1 rst = 1'b0;
    done_cnt = 0;
    repeat (12) begin
      tick();
      if (done8 === 1'b1) done_cnt++;
    end
    chk("arst_no_done", 32'(done_cnt), 32'd0);
    prev_d8 = '0; prev_b8 = 1'b0;
    op8(8'h5A, 8'h3C, 8'h1E, 1'b0, "post_rst");

    // WIDTH=4 exhaustive
    for (int i = 0; i < 256; i++) begin
      ta = 4'(i >> 4); tb_ = 4'(i);
      ed4 = ta - tb_;
      eb4 = (ta < tb_);
      start4 = 1'b1; a4 = ta; b4 = tb_;
      tick();
      start4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom);
      chk("w4_hold_diff", 32'(diff4), 32'(prev_d4));
      chk("w4_hold_bo", 32'(bo4), 32'(prev_b4));
      n = 0;
      while (busy4 === 1'b1 && n < 10) begin
        n++;
        tick();
      end
      chk("w4_busy_cycles", 32'(n), 32'd4);
      chk("w4_done", 32'(done4), 32'd1);
      chk("w4_diff", 32'(diff4), 32'(ed4));
      chk("w4_borrow", 32'(bo4), 32'(eb4));
      tick();
      chk("w4_idle_hold", 32'(diff4), 32'(ed4));
      prev_d4 = ed4; prev_b4 = eb4;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
